// File: rtl/jk_using_t.sv
// jk_using_t: bank of JK flip-flops, each a T flop fed by JK-to-T conversion.
// Define JK_TOGGLE_COUNT_EN to add toggle_cnt, counting edges where any q bit changes.
module jk_using_t #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
`ifdef JK_TOGGLE_COUNT_EN
    ,
    output logic [15:0]      toggle_cnt
`endif
);
    logic [WIDTH-1:0] t;
    assign t = en ? ((j & ~q) | (k & q)) : '0;
    assign q_bar = ~q;
    always_ff @(posedge clock)
        q <= !rst ? RESET_VALUE : q ^ t;
`ifdef JK_TOGGLE_COUNT_EN
    // any set bit of t flips q, so |t marks a change of state
    always_ff @(posedge clock)
        toggle_cnt <= !rst ? 16'd0 : toggle_cnt + {15'd0, |t};
`endif
endmodule

// File: tb/tb_jk_using_t.sv
// tb_jk_using_t: directed and random checks of jk_using_t against a truth-table model.
// Also checks toggle_cnt when JK_TOGGLE_COUNT_EN is defined.
module tb_jk_using_t;
    localparam int W = 4;
    logic         clock = 1'b0;
    logic         rst, en;
    logic [W-1:0] j, k, q, q_bar;
    logic [W-1:0] q_m;
    int           cnt_m;
    int           errors = 0;
    int           checks = 0;
`ifdef JK_TOGGLE_COUNT_EN
    logic [15:0]  toggle_cnt;
`endif

    jk_using_t #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .clock(clock),
        .rst(rst),
        .en(en),
        .j(j),
        .k(k),
        .q(q),
        .q_bar(q_bar)
`ifdef JK_TOGGLE_COUNT_EN
        ,
        .toggle_cnt(toggle_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic step(input string tag, input logic r, input logic e,
                        input logic [W-1:0] jj, input logic [W-1:0] kk, input bit g);
        logic [W-1:0] nq;
        rst = r;
        en  = e;
        if (g)
            repeat (3) begin
                j = W'($urandom);
                k = W'($urandom);
                #2;
            end
        j = jj;
        k = kk;
        @(posedge clock);
        if (!r) begin
            q_m   = '0;
            cnt_m = 0;
        end else if (e) begin
            for (int i = 0; i < W; i++)
                nq[i] = (jj[i] && kk[i]) ? !q_m[i] : jj[i] ? 1'b1 : kk[i] ? 1'b0 : q_m[i];
            if (nq != q_m) cnt_m = (cnt_m + 1) % 65536;
            q_m = nq;
        end
        #1;
        checks++;
        assert (q === q_m) else begin
            errors++;
            $error("FAIL %s q: got %b want %b", tag, q, q_m);
        end
        checks++;
        assert (q_bar === ~q_m) else begin
            errors++;
            $error("FAIL %s q_bar: got %b want %b", tag, q_bar, ~q_m);
        end
`ifdef JK_TOGGLE_COUNT_EN
        checks++;
        assert (toggle_cnt === 16'(cnt_m)) else begin
            errors++;
            $error("FAIL %s toggle_cnt: got %0d want %0d", tag, toggle_cnt, cnt_m);
        end
`endif
    endtask

    initial begin
        q_m   = '0;
        cnt_m = 0;
        rst   = 1'b0;
        en    = 1'b0;
        j     = 'x;
        k     = 'x;
        #1;
        step("reset", 1'b0, 1'b1, 'x, 'x, 1'b0);
        repeat (3) step("hold", 1'b1, 1'b1, '0, '0, 1'b0);
        step("set", 1'b1, 1'b1, '1, '0, 1'b0);
        step("clear", 1'b1, 1'b1, '0, '1, 1'b0);
        repeat (4) step("toggle", 1'b1, 1'b1, '1, '1, 1'b0);
        step("mixed", 1'b1, 1'b1, 4'b0101, 4'b0011, 1'b0);
        repeat (2) step("en_off", 1'b1, 1'b0, '1, '0, 1'b0);
        step("en_off_tgl", 1'b1, 1'b0, '1, '1, 1'b0);
        repeat (6) step("glitch", 1'b1, 1'b1, W'($urandom), W'($urandom), 1'b1);
        repeat (40) step("random", ($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                         W'($urandom), W'($urandom), $urandom_range(0, 1) == 1);
        step("pre_set", 1'b1, 1'b1, '1, '0, 1'b0);
        repeat (3) step("run_tgl", 1'b1, 1'b1, '1, '1, 1'b0);
        step("mid_reset", 1'b0, 1'b1, '1, '1, 1'b0);
        repeat (3) step("post_tgl", 1'b1, 1'b1, '1, '1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
